// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared widths, read-latency default and DMA state encoding
package soc_mem_pkg;
  localparam int AW_DEF = 19;
  localparam int DW_DEF = 19;
  localparam int RD_LAT_DEF = 1;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} dma_state_e;
endpackage

// File: rtl/mem_dma_master_if.sv
// mem_dma_master_if: single-port memory strobe bus between the DMA master and data memory
interface mem_dma_master_if #(parameter int AW = 19, parameter int DW = 19);
  logic mem_read;
  logic mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  modport master(output mem_read, mem_write, addr, write_data, input read_data);
  modport slave(input mem_read, mem_write, addr, write_data, output read_data);
endinterface

// File: rtl/mem_dma_master.sv
// mem_dma_master: block-copy DMA over the memory strobe bus; MEM_DMA_CHECKSUM_EN adds an XOR checksum of copied words
module mem_dma_master
  import soc_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
`ifdef MEM_DMA_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  mem_dma_master_if.master mem
);
  dma_state_e st, st_nx;
  logic [AW-1:0] src_q, dst_q, len_q, cnt_nx, addr_nx;
  logic [DW-1:0] wd_nx;
  logic [1:0] wcnt, wcnt_nx;
  logic acc, cap;
  assign acc = st == IDLE && start;
  always_comb begin
    st_nx = st;
    cnt_nx = count;
    wcnt_nx = wcnt;
    cap = 1'b0;
    case (st)
      IDLE: if (start) begin
        st_nx = len == '0 ? DONE : RD;
        cnt_nx = '0;
      end
      RD: begin
        st_nx = WAIT;
        wcnt_nx = '0;
      end
      WAIT: if (wcnt == 2'(RD_LAT - 1)) begin
        st_nx = WR;
        cap = 1'b1;
      end else wcnt_nx = wcnt + 2'd1;
      WR: begin
        cnt_nx = count + 1'b1;
        st_nx = cnt_nx == len_q ? DONE : RD;
      end
      DONE: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
    if (abort && (st == RD || st == WAIT || st == WR)) begin
      st_nx = IDLE;
      cnt_nx = count;
      cap = 1'b0;
    end
    // outputs are registered, so they are computed for the state being entered
    addr_nx = st_nx == RD ? (acc ? src : src_q) + cnt_nx :
              st_nx == WR ? dst_q + cnt_nx : mem.addr;
    wd_nx = cap ? mem.read_data : mem.write_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      count <= '0;
      wcnt <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      mem.mem_read <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.addr <= '0;
      mem.write_data <= '0;
    end else begin
      st <= st_nx;
      count <= cnt_nx;
      wcnt <= wcnt_nx;
      if (acc) begin
        src_q <= src;
        dst_q <= dst;
        len_q <= len;
      end
      busy <= st_nx != IDLE;
      done <= st_nx == DONE;
      mem.mem_read <= st_nx == RD;
      mem.mem_write <= st_nx == WR;
      mem.addr <= addr_nx;
      mem.write_data <= wd_nx;
    end
  end
`ifdef MEM_DMA_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n || acc) checksum <= '0;
    else if (cap) checksum <= checksum ^ mem.read_data;
  end
`endif
endmodule

// File: tb/tb_mem_dma_master.sv
// tb_mem_dma_master: randomized scoreboard bench with a word-level copy model and a latency-accurate memory
module tb_mem_dma_master;
  localparam int AW = 19;
  localparam int DW = 19;
`ifdef MEM_DMA_CHECKSUM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int CPW = 2 + LAT;
  typedef struct {bit wr; logic [AW-1:0] a; logic [DW-1:0] d;} ev_t;
  typedef struct {int cyc; logic [AW-1:0] cnt; logic [DW-1:0] cs;} dn_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [AW-1:0] src = 0, dst = 0, len = 0;
  logic busy, done;
  logic [AW-1:0] count;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif
  int tests = 0, fails = 0, pcnt = 0;
  ev_t evq[$];
  dn_t dq[$];
  ev_t me;
  dn_t md;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] refm [0:(1<<AW)-1];
  logic [DW-1:0] pipe [LAT];
  logic poke_en = 0;
  logic [AW-1:0] poke_a = 0;
  logic [DW-1:0] poke_v = 0;
  mem_dma_master_if #(.AW(AW), .DW(DW)) bus();
  mem_dma_master #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src(src), .dst(dst), .len(len), .busy(busy), .done(done), .count(count),
`ifdef MEM_DMA_CHECKSUM_EN
    .checksum(checksum),
`endif
    .mem(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] f(int a);
    return DW'(a * 7 + 13);
  endfunction
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", n, act, exp, $time);
    end
  endfunction
  // memory: read data appears in the last WAIT cycle, RD_LAT cycles after the RD strobe is sampled
  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = f(i);
    foreach (pipe[i]) pipe[i] = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_write) ram[bus.addr] <= bus.write_data;
      if (poke_en) ram[poke_a] <= poke_v;
      pipe[0] <= bus.mem_read ? ram[bus.addr] : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.read_data = pipe[LAT-1];
  always @(posedge clk) begin
    #1;
    pcnt++;
    chk("strobe_excl", {31'b0, bus.mem_read & bus.mem_write}, 0);
    if (bus.mem_read || bus.mem_write) begin
      if (evq.size() == 0) chk("unexpected_strobe", {bus.mem_write, 12'b0, bus.addr}, 0);
      else begin
        me = evq.pop_front();
        chk("strobe_kind", {31'b0, bus.mem_write}, {31'b0, me.wr});
        chk("addr", bus.addr, me.a);
        if (me.wr) chk("write_data", bus.write_data, me.d);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        md = dq.pop_front();
        chk("done_cycle", pcnt, md.cyc);
        chk("done_count", count, md.cnt);
`ifdef MEM_DMA_CHECKSUM_EN
        chk("checksum", checksum, md.cs);
`endif
      end
    end
  end
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    poke_en = 1; poke_a = a; poke_v = v; refm[a] = v;
    @(negedge clk);
    poke_en = 0;
  endtask
  task automatic xfer(input logic [AW-1:0] s, d, l, input int ab, input bit bs);
    int k;
    int c;
    logic [DW-1:0] cs = '0;
    logic [DW-1:0] v;
    k = ab != 0 ? ab : int'(l);
    for (int i = 0; i < k; i++) begin
      v = refm[AW'(s + i)];
      evq.push_back('{0, AW'(s + i), '0});
      evq.push_back('{1, AW'(d + i), v});
      refm[AW'(d + i)] = v;
      cs ^= v;
    end
    @(negedge clk);
    src = s; dst = d; len = l; start = 1; abort = $urandom_range(0, 1);
    c = pcnt;
    if (ab == 0) dq.push_back('{c + 1 + int'(l) * CPW, l, cs});
    @(negedge clk);
    start = 0; abort = 0;
    src = AW'($urandom); dst = AW'($urandom); len = AW'($urandom);
    if (l == 0) begin
      chk("zl_busy_on", {31'b0, busy}, 1);
      @(negedge clk);
      chk("zl_busy_off", {31'b0, busy}, 0);
    end
    if (bs) begin
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    if (ab != 0) begin
      repeat ((ab - 1) * CPW + 1 + LAT) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_count", count, ab - 1);
      chk("abort_strobes", {30'b0, bus.mem_read, bus.mem_write}, 0);
    end
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk("idle_timeout", {31'b0, busy}, 0);
    chk("events_left", evq.size(), 0);
    chk("done_left", dq.size(), 0);
  endtask
  initial begin
    for (int i = 0; i < (1<<AW); i++) refm[i] = f(i);
    repeat (3) @(negedge clk);
    chk("rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_busy_done", {30'b0, busy, done}, 0);
    chk("rst_count", count, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) poke(AW'(100 + i), DW'(138 + i));
    xfer(100, 200, 4, 0, 0);
    for (int i = 0; i < 4; i++) chk("basic_mem", ram[200 + i], 138 + i);
    chk("basic_count", count, 4);
    xfer(AW'($urandom), AW'($urandom), 0, 0, 0);
    xfer(19'h7FFFE, 19'h7F000, 4, 0, 0);
    xfer(500, 600, 8, 3, 0);
    xfer(500, 600, 8, 0, 0);
    xfer(700, 800, 3, 0, 1);
`ifdef MEM_DMA_CHECKSUM_EN
    poke(300, 19'h00001); poke(301, 19'h00003); poke(302, 19'h7FFFF);
    xfer(300, 900, 3, 0, 0);
    chk("checksum_final", checksum, 19'h7FFFD);
`endif
    for (int n = 0; n < 20; n++) begin
      logic [AW-1:0] s, d, l;
      int ab;
      l = AW'($urandom_range(1, 6));
      s = AW'($urandom);
      d = $urandom_range(0, 1) ? AW'(s + $urandom_range(1, 4)) : AW'($urandom);
      ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, int'(l))) : 0;
      xfer(s, d, l, ab, 0);
    end
    evq.push_back('{0, 19'd1000, '0});
    @(negedge clk);
    src = 1000; dst = 1100; len = 3; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 0);
    chk("mid_rst_addr", bus.addr, 0);
    chk("mid_rst_wdata", bus.write_data, 0);
    chk("mid_rst_busy_done", {30'b0, busy, done}, 0);
    chk("mid_rst_count", count, 0);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("mid_rst_events_left", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
